// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: synchronised and deglitched pad inputs, register-bus control of direction/type/output
// data and per-pin edge or level interrupts. Defining GPIO_ATOMIC_EN adds the OUT_SET, OUT_CLR and INT_SET ports.
module gpio_bank #(
   parameter int NPIN     = 32,
   parameter int DG_DEPTH = 3,
   parameter int PWM_BASE = 16,
   parameter int PWM_W    = 8
) (
   input  logic              mclk,
   input  logic              h_reset,
   input  logic              pulse_1us,
   input  logic              cfg_gpio_dgmode,
   input  logic              reg_cs,
   input  logic              reg_wr,
   input  logic [3:0]        reg_addr,
   input  logic [31:0]       reg_wdata,
   input  logic [3:0]        reg_be,
   output logic [31:0]       reg_rdata,
   output logic              reg_ack,
   input  logic [NPIN-1:0]   pad_gpio_in,
   output logic [NPIN-1:0]   pad_gpio_out,
   output logic [NPIN-1:0]   cfg_gpio_dir_sel,
   output logic [NPIN-1:0]   cfg_gpio_out_type,
   output logic [PWM_W-1:0]  pwm_gpio_in,
   output logic [NPIN-1:0]   gpio_intr,
   output logic              gpio_irq
);

   localparam int CW = $clog2(DG_DEPTH);

   logic [NPIN-1:0]         r_dir, r_type, r_out, r_pos, r_neg, r_lvl, r_pol, r_stat, r_mask;
   logic [NPIN-1:0]         r_s1, r_s2, r_dg, r_prev;
   logic [NPIN-1:0][CW-1:0] r_cnt;
   logic                    r_ack;
   logic [31:0]             r_rdata;

   logic                    w_acc, w_wr, w_rd, w_tick;
   logic [15:0]             w_wsel;
   logic [31:0]             w_bm32, w_rmux;
   logic [NPIN-1:0]         w_bm, w_wd, w_mb;
   logic [NPIN-1:0]         w_out_nxt, w_clr, w_iset;
   logic [NPIN-1:0]         w_edge_evt, w_lvl_evt, w_stat_nxt;

   // One access per ack: a request is only taken while no ack is outstanding.
   assign w_acc  = reg_cs & ~r_ack;
   assign w_wr   = w_acc & reg_wr;
   assign w_rd   = w_acc & ~reg_wr;
   assign w_wsel = w_wr ? (16'd1 << reg_addr) : 16'd0;
   assign w_tick = cfg_gpio_dgmode | pulse_1us;

   assign w_bm32 = {{8{reg_be[3]}}, {8{reg_be[2]}}, {8{reg_be[1]}}, {8{reg_be[0]}}};
   assign w_bm   = w_bm32[NPIN-1:0];
   assign w_wd   = reg_wdata[NPIN-1:0];
   assign w_mb   = w_wd & w_bm;

   always_comb begin
      w_out_nxt = r_out;
      if (w_wsel[2]) w_out_nxt = (r_out & ~w_bm) | w_mb;
`ifdef GPIO_ATOMIC_EN
      if (w_wsel[3]) w_out_nxt = r_out | w_mb;
      if (w_wsel[4]) w_out_nxt = r_out & ~w_mb;
`endif
   end

   assign w_clr = w_wsel[10] ? w_mb : '0;
`ifdef GPIO_ATOMIC_EN
   assign w_iset = w_wsel[12] ? w_mb : '0;
`else
   assign w_iset = '0;
`endif

   assign w_edge_evt = ~r_dir & ~r_lvl & ((r_dg & ~r_prev & r_pos) | (~r_dg & r_prev & r_neg));
   assign w_lvl_evt  = ~r_dir & r_lvl & ~(r_dg ^ r_pol);
   // Edge events beat a same-cycle clear; a level event yields to the clear and re-sets a cycle later.
   assign w_stat_nxt = (r_stat & ~w_clr) | w_edge_evt | (w_lvl_evt & ~w_clr) | w_iset;

   always_comb begin
      w_rmux = '0;
      case (reg_addr)
         4'd0:    w_rmux = 32'(r_dir);
         4'd1:    w_rmux = 32'(r_type);
         4'd2:    w_rmux = 32'(r_out);
         4'd5:    w_rmux = 32'(r_dg);
         4'd6:    w_rmux = 32'(r_pos);
         4'd7:    w_rmux = 32'(r_neg);
         4'd8:    w_rmux = 32'(r_lvl);
         4'd9:    w_rmux = 32'(r_pol);
         4'd10:   w_rmux = 32'(r_stat);
         4'd11:   w_rmux = 32'(r_mask);
         default: w_rmux = '0;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (h_reset) begin
         r_ack   <= 1'b0;
         r_rdata <= '0;
         r_dir   <= '0;
         r_type  <= '0;
         r_out   <= '0;
         r_pos   <= '0;
         r_neg   <= '0;
         r_lvl   <= '0;
         r_pol   <= '0;
         r_stat  <= '0;
         r_mask  <= '0;
      end else begin
         r_ack  <= w_acc;
         if (w_rd) r_rdata <= w_rmux;
         if (w_wsel[0])  r_dir  <= (r_dir  & ~w_bm) | w_mb;
         if (w_wsel[1])  r_type <= (r_type & ~w_bm) | w_mb;
         if (w_wsel[6])  r_pos  <= (r_pos  & ~w_bm) | w_mb;
         if (w_wsel[7])  r_neg  <= (r_neg  & ~w_bm) | w_mb;
         if (w_wsel[8])  r_lvl  <= (r_lvl  & ~w_bm) | w_mb;
         if (w_wsel[9])  r_pol  <= (r_pol  & ~w_bm) | w_mb;
         if (w_wsel[11]) r_mask <= (r_mask & ~w_bm) | w_mb;
         r_out  <= w_out_nxt;
         r_stat <= w_stat_nxt;
      end
   end

   // The state flips on the DG_DEPTH-th consecutive differing sample.
   always_ff @(posedge mclk) begin
      if (h_reset) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_dg   <= '0;
         r_prev <= '0;
         r_cnt  <= '0;
      end else begin
         r_s1   <= pad_gpio_in;
         r_s2   <= r_s1;
         r_prev <= r_dg;
         if (w_tick) begin
            for (int i = 0; i < NPIN; i++) begin
               if (r_s2[i] == r_dg[i]) begin
                  r_cnt[i] <= '0;
               end else if (r_cnt[i] == CW'(DG_DEPTH - 1)) begin
                  r_dg[i]  <= ~r_dg[i];
                  r_cnt[i] <= '0;
               end else begin
                  r_cnt[i] <= r_cnt[i] + CW'(1);
               end
            end
         end
      end
   end

   assign reg_ack           = r_ack;
   assign reg_rdata         = r_rdata;
   assign pad_gpio_out      = r_out;
   assign cfg_gpio_dir_sel  = r_dir;
   assign cfg_gpio_out_type = r_type;
   assign pwm_gpio_in       = r_dg[PWM_BASE +: PWM_W];
   assign gpio_intr         = r_stat & r_mask;
   assign gpio_irq          = |gpio_intr;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: reset, handshake, byte enables, deglitch timing, edge/level interrupts, atomic ops.
module tb_gpio_bank;

   logic        mclk = 1'b0;
   logic        h_reset = 1'b1;
   logic        pulse_1us = 1'b0;
   logic        cfg_gpio_dgmode = 1'b1;
   logic        reg_cs = 1'b0;
   logic        reg_wr = 1'b0;
   logic [3:0]  reg_addr = '0;
   logic [31:0] reg_wdata = '0;
   logic [3:0]  reg_be = '0;
   logic [31:0] reg_rdata;
   logic        reg_ack;
   logic [31:0] pad_gpio_in = '0;
   logic [31:0] pad_gpio_out;
   logic [31:0] cfg_gpio_dir_sel;
   logic [31:0] cfg_gpio_out_type;
   logic [7:0]  pwm_gpio_in;
   logic [31:0] gpio_intr;
   logic        gpio_irq;

   int n_pass = 0;
   int n_tot  = 0;

   gpio_bank #(.NPIN(32), .DG_DEPTH(3), .PWM_BASE(16), .PWM_W(8)) dut (
      .mclk(mclk), .h_reset(h_reset), .pulse_1us(pulse_1us), .cfg_gpio_dgmode(cfg_gpio_dgmode),
      .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_be(reg_be),
      .reg_rdata(reg_rdata), .reg_ack(reg_ack), .pad_gpio_in(pad_gpio_in), .pad_gpio_out(pad_gpio_out),
      .cfg_gpio_dir_sel(cfg_gpio_dir_sel), .cfg_gpio_out_type(cfg_gpio_out_type),
      .pwm_gpio_in(pwm_gpio_in), .gpio_intr(gpio_intr), .gpio_irq(gpio_irq)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      @(posedge mclk); #1;
      reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d; reg_be = be;
      @(posedge mclk); #1;
      chk("wr_ack", 32'(reg_ack), 32'd1);
      reg_cs = 1'b0; reg_wr = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      @(posedge mclk); #1;
      reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = a;
      @(posedge mclk); #1;
      chk("rd_ack", 32'(reg_ack), 32'd1);
      d = reg_rdata;
      reg_cs = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic        seen;

      // reset
      repeat (2) @(posedge mclk);
      #1;
      chk("rst_ack", 32'(reg_ack), 32'd0);
      h_reset = 1'b0;
      chk("rst_out", pad_gpio_out, 32'd0);
      chk("rst_irq", 32'(gpio_irq), 32'd0);
      for (int a = 0; a < 16; a++) begin
         rd(4'(a), d);
         chk($sformatf("rst_rd%0d", a), d, 32'd0);
      end

      // handshake and byte enables
      wr(4'd0, 32'h0000_FFFF, 4'b0011);
      chk("ack_drop", 32'(reg_ack), 32'd1);
      @(posedge mclk); #1;
      chk("ack_low", 32'(reg_ack), 32'd0);
      rd(4'd0, d);
      chk("dir_rb1", d, 32'h0000_FFFF);
      wr(4'd0, 32'hFFFF_0000, 4'b1000);
      rd(4'd0, d);
      chk("dir_rb2", d, 32'hFF00_FFFF);
      chk("dir_port", cfg_gpio_dir_sel, 32'hFF00_FFFF);

      // cs held high: ack every other cycle
      @(posedge mclk); #1;
      reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = 4'd0;
      @(posedge mclk); #1; chk("hold_a1", 32'(reg_ack), 32'd1);
      @(posedge mclk); #1; chk("hold_a2", 32'(reg_ack), 32'd0);
      @(posedge mclk); #1; chk("hold_a3", 32'(reg_ack), 32'd1);
      chk("hold_rd", reg_rdata, 32'hFF00_FFFF);
      reg_cs = 1'b0;
      wr(4'd0, 32'h0, 4'hF);
      wr(4'd1, 32'h0000_0300, 4'hF);
      chk("type_port", cfg_gpio_out_type, 32'h0000_0300);

      // deglitch: 2 sync + 3 samples
      @(posedge mclk); #1;
      pad_gpio_in[16] = 1'b1; pad_gpio_in[0] = 1'b1;
      repeat (4) @(posedge mclk);
      #1; chk("dg_early", 32'(pwm_gpio_in[0]), 32'd0);
      @(posedge mclk); #1; chk("dg_flip", 32'(pwm_gpio_in[0]), 32'd1);
      pad_gpio_in[17] = 1'b1;
      repeat (2) @(posedge mclk);
      #1; pad_gpio_in[17] = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(posedge mclk); #1;
         seen = seen | pwm_gpio_in[1];
      end
      chk("dg_glitch", 32'(seen), 32'd0);
      rd(4'd5, d);
      chk("in_reg", d, 32'h0001_0001);

      // edge interrupt on pin4
      wr(4'd6, 32'h10, 4'hF);
      wr(4'd11, 32'h10, 4'hF);
      @(posedge mclk); #1;
      pad_gpio_in[4] = 1'b1;
      repeat (5) @(posedge mclk);
      #1; chk("irq_pre", 32'(gpio_irq), 32'd0);
      @(posedge mclk); #1; chk("irq_rise", 32'(gpio_irq), 32'd1);
      rd(4'd10, d);
      chk("stat_edge", d, 32'h10);
      wr(4'd10, 32'h10, 4'hF);
      rd(4'd10, d);
      chk("stat_w1c", d, 32'h0);
      @(posedge mclk); #1;
      pad_gpio_in[4] = 1'b0;
      repeat (8) @(posedge mclk);
      #1; pad_gpio_in[4] = 1'b1;
      repeat (5) @(posedge mclk);
      #1;
      reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = 4'd10; reg_wdata = 32'h10; reg_be = 4'hF;
      @(posedge mclk); #1;
      reg_cs = 1'b0; reg_wr = 1'b0;
      rd(4'd10, d);
      chk("stat_setwins", d, 32'h10);
      wr(4'd10, 32'h10, 4'hF);

      // level interrupt on pin7, active-low
      wr(4'd8, 32'h80, 4'hF);
      wr(4'd11, 32'h90, 4'hF);
      rd(4'd10, d);
      chk("stat_lvl", d, 32'h80);
      wr(4'd10, 32'h80, 4'hF);
      chk("lvl_clr", gpio_intr, 32'h0);
      @(posedge mclk); #1;
      chk("lvl_reset", gpio_intr, 32'h80);
      pad_gpio_in[7] = 1'b1;
      repeat (8) @(posedge mclk);
      wr(4'd10, 32'h80, 4'hF);
      repeat (2) @(posedge mclk);
      rd(4'd10, d);
      chk("lvl_gone", d, 32'h0);
      chk("lvl_irq", 32'(gpio_irq), 32'd0);

      // atomic output update
      wr(4'd2, 32'hA5, 4'hF);
      wr(4'd3, 32'h0F, 4'hF);
      rd(4'd2, d);
`ifdef GPIO_ATOMIC_EN
      chk("out_set", d, 32'hAF);
`else
      chk("out_set", d, 32'hA5);
`endif
      wr(4'd3, 32'h100, 4'b0001);
      wr(4'd4, 32'hA0, 4'hF);
      rd(4'd2, d);
`ifdef GPIO_ATOMIC_EN
      chk("out_clr", d, 32'h0F);
      chk("out_port", pad_gpio_out, 32'h0F);
`else
      chk("out_clr", d, 32'hA5);
      chk("out_port", pad_gpio_out, 32'hA5);
`endif
      rd(4'd3, d);
      chk("set_rd0", d, 32'h0);
      wr(4'd13, 32'hFFFF_FFFF, 4'hF);
      rd(4'd13, d);
      chk("rsv_rd0", d, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
